// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform turning-point analyzer.
package wave_pkg;

  localparam int          SAMPLE_W     = 8;
  localparam int          PERIOD_W     = 16;
  localparam int unsigned HYST_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2
  } state_t;

endpackage

// File: rtl/wave_extreme_tracker.sv
// Running max/min registers and the hysteresis turning-point compares.
module wave_extreme_tracker
  import wave_pkg::*;
#(
  parameter int unsigned HYST = HYST_DEFAULT
) (
  input  logic                clk,
  input  logic                valid_i,
  input  state_t              state_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-1:0] run_max_o,
  output logic [SAMPLE_W-1:0] run_min_o,
  output logic                peak_hit_o,
  output logic                trough_hit_o
);

  localparam logic [SAMPLE_W:0] HYST_W = (SAMPLE_W+1)'(HYST);

  logic [SAMPLE_W-1:0] max_q, max_d;
  logic [SAMPLE_W-1:0] min_q, min_d;
  logic [SAMPLE_W:0]   s_ext;

  // Compares are one bit wider so sample+HYST and min+HYST cannot wrap.
  assign s_ext        = {1'b0, sample_i};
  assign peak_hit_o   = valid_i && (state_i == ST_RISING) &&
                        ((s_ext + HYST_W) <= {1'b0, max_q});
  assign trough_hit_o = valid_i && (state_i == ST_FALLING) &&
                        (s_ext >= ({1'b0, min_q} + HYST_W));

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (valid_i) begin
      case (state_i)
        ST_IDLE: begin
          max_d = sample_i;
          min_d = sample_i;
        end
        ST_RISING: begin
          if (peak_hit_o)           min_d = sample_i;
          else if (sample_i > max_q) max_d = sample_i;
        end
        ST_FALLING: begin
          if (trough_hit_o)         max_d = sample_i;
          else if (sample_i < min_q) min_d = sample_i;
        end
        default: ;
      endcase
    end
  end

  // Extremes are reloaded from IDLE on the first sample, so they need no reset.
  always_ff @(posedge clk) begin
    max_q <= max_d;
    min_q <= min_d;
  end

  assign run_max_o = max_q;
  assign run_min_o = min_q;

endmodule

// File: rtl/wave_analyzer.sv
// Peak/trough/period analyzer with hysteresis; optional amplitude output
// enabled by defining WAVE_ANALYZER_AMP_EN.
module wave_analyzer
  import wave_pkg::*;
#(
  parameter int unsigned HYST = HYST_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] peak_val,
  output logic [SAMPLE_W-1:0] trough_val,
  output logic [PERIOD_W-1:0] period,
  output logic                meas_valid,
  output logic                dir_up,
  output logic                locked
`ifdef WAVE_ANALYZER_AMP_EN
  ,
  output logic [SAMPLE_W-1:0] amplitude
`endif
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                prior_q, prior_d;
  logic                seen_q, seen_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [SAMPLE_W-1:0] trough_q, trough_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                meas_q, meas_d;
  logic                dir_q, dir_d;
  logic                locked_q, locked_d;
  logic                sat;

  logic [SAMPLE_W-1:0] run_max, run_min;
  logic                peak_hit, trough_hit;

  wave_extreme_tracker #(.HYST(HYST)) u_tracker (
    .clk          (clk),
    .valid_i      (sample_valid),
    .state_i      (state_q),
    .sample_i     (sample_in),
    .run_max_o    (run_max),
    .run_min_o    (run_min),
    .peak_hit_o   (peak_hit),
    .trough_hit_o (trough_hit)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign sat     = (cnt_inc == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prior_d  = prior_q;
    seen_d   = seen_q;
    peak_d   = peak_q;
    trough_d = trough_q;
    period_d = period_q;
    meas_d   = 1'b0;
    locked_d = locked_q;
    if (sample_valid) begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_RISING;
        end
        ST_RISING, ST_FALLING: begin
          cnt_d = cnt_inc;
          // A saturated count means the signal stalled: drop lock and history.
          if (sat) begin
            locked_d = 1'b0;
            seen_d   = 1'b0;
            prior_d  = 1'b0;
          end
          if (peak_hit) begin
            peak_d  = run_max;
            state_d = ST_FALLING;
          end
          if (trough_hit) begin
            trough_d = run_min;
            state_d  = ST_RISING;
            cnt_d    = '0;
            prior_d  = 1'b1;
            if (prior_q && !sat) begin
              period_d = cnt_inc;
              meas_d   = 1'b1;
              seen_d   = 1'b1;
              if (seen_q) locked_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    dir_d = (state_d == ST_RISING);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prior_q  <= 1'b0;
      seen_q   <= 1'b0;
      peak_q   <= '0;
      trough_q <= '0;
      period_q <= '0;
      meas_q   <= 1'b0;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prior_q  <= prior_d;
      seen_q   <= seen_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
      period_q <= period_d;
      meas_q   <= meas_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
    end
  end

`ifdef WAVE_ANALYZER_AMP_EN
  logic [SAMPLE_W-1:0] amp_q;

  // Uses the freshly confirmed trough so amplitude lines up with meas_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      amp_q <= '0;
    end else if (meas_d) begin
      amp_q <= (peak_q >= run_min) ? peak_q - run_min : '0;
    end
  end

  assign amplitude = amp_q;
`endif

  assign peak_val   = peak_q;
  assign trough_val = trough_q;
  assign period     = period_q;
  assign meas_valid = meas_q;
  assign dir_up     = dir_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_wave_analyzer.sv
// Randomized and directed bench for wave_analyzer against a behavioural model.
module tb_wave_analyzer;

  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample_in = 8'd0;
  logic [7:0]  peak_val, trough_val;
  logic [15:0] period;
  logic        meas_valid, dir_up, locked;
  logic [7:0]  amp_obs;

`ifdef WAVE_ANALYZER_AMP_EN
  logic [7:0] amplitude;
  assign amp_obs = amplitude;
`else
  assign amp_obs = 8'd0;
`endif

  wave_analyzer #(.HYST(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .peak_val     (peak_val),
    .trough_val   (trough_val),
    .period       (period),
    .meas_valid   (meas_valid),
    .dir_up       (dir_up),
    .locked       (locked)
`ifdef WAVE_ANALYZER_AMP_EN
    ,
    .amplitude    (amplitude)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: mode 0 = waiting for first sample, 1 = rising, 2 = falling.
  int m_mode = 0, m_hi = 0, m_lo = 0, m_cnt = 0, m_streak = 0;
  int m_peak = 0, m_trough = 0, m_period = 0, m_amp = 0;
  bit m_have = 0, m_locked = 0, m_meas = 0;

  task automatic model_step(input bit r, input bit v, input int s);
    bit had, sat;
    m_meas = 0;
    if (!r) begin
      m_mode = 0; m_peak = 0; m_trough = 0; m_period = 0; m_amp = 0;
      m_locked = 0; m_cnt = 0; m_have = 0; m_streak = 0;
    end else if (v) begin
      if (m_mode == 0) begin
        m_hi = s; m_lo = s; m_cnt = 0; m_mode = 1;
      end else begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        sat = (m_cnt == 65535);
        had = m_have;
        if (sat) begin m_locked = 0; m_streak = 0; m_have = 0; end
        if (m_mode == 1) begin
          if (s + H <= m_hi) begin m_peak = m_hi; m_lo = s; m_mode = 2; end
          else if (s > m_hi) m_hi = s;
        end else begin
          if (s >= m_lo + H) begin
            m_trough = m_lo; m_hi = s; m_mode = 1;
            if (had && !sat) begin
              m_period = m_cnt; m_meas = 1; m_streak++;
              if (m_streak >= 2) m_locked = 1;
              m_amp = (m_peak >= m_trough) ? m_peak - m_trough : 0;
            end
            m_cnt = 0; m_have = 1;
          end else if (s < m_lo) m_lo = s;
        end
      end
    end
  endtask

  int cyc = 0, n_meas = 0, last_meas_cyc = 0, last_gap = 0;

  task automatic drive(input bit r, input bit v, input int s);
    logic [63:0] exp_v, obs_v;
    int e_amp;
    rst_n = r; sample_valid = v; sample_in = 8'(s);
    @(posedge clk);
    model_step(r, v, s);
    #1;
    cyc++;
`ifdef WAVE_ANALYZER_AMP_EN
    e_amp = m_amp;
`else
    e_amp = 0;
`endif
    exp_v = {21'd0, 8'(m_peak), 8'(m_trough), 16'(m_period), m_meas,
             (m_mode == 1), m_locked, 8'(e_amp)};
    obs_v = {21'd0, peak_val, trough_val, period, meas_valid, dir_up, locked, amp_obs};
    chk("outs", obs_v, exp_v);
    if (meas_valid) begin
      n_meas++;
      last_gap = cyc - last_meas_cyc;
      last_meas_cyc = cyc;
    end
  endtask

  task automatic put(input int s, input bit tog);
    drive(1, 1, s);
    if (tog) drive(1, 0, 8'hAA);
  endtask

  task automatic wave(input bit tog);
    for (int x = 0; x < 256; x++) put(x, tog);
    for (int x = 254; x >= 1; x--) put(x, tog);
  endtask

  task automatic rsample(input int x, input bit nz);
    int v;
    v = x + (nz ? $urandom_range(0, 2) - 1 : 0);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    if ($urandom_range(0, 3) == 0) drive(1, 0, $urandom_range(0, 255));
    drive(1, 1, v);
    if ($urandom_range(0, 19) == 0) for (int k = 0; k < 3; k++) drive(1, 1, v);
  endtask

  initial begin
    int lo, hi, st, fall_k;
    bit nz;

    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    chk("rst_peak", peak_val, 0);
    chk("rst_trough", trough_val, 0);
    chk("rst_period", period, 0);
    chk("rst_meas", meas_valid, 0);
    chk("rst_dir", dir_up, 0);
    chk("rst_locked", locked, 0);

    n_meas = 0;
    for (int w = 0; w < 4; w++) wave(0);
    chk("tri_nmeas", n_meas, 2);
    chk("tri_gap", last_gap, 510);
    chk("tri_period", period, 510);
    chk("tri_peak", peak_val, 255);
    chk("tri_trough", trough_val, 0);
    chk("tri_locked", locked, 1);

    n_meas = 0;
    for (int w = 0; w < 4; w++) wave(1);
    chk("tog_nmeas", n_meas, 4);
    chk("tog_gap", last_gap, 1020);
    chk("tog_period", period, 510);
`ifdef WAVE_ANALYZER_AMP_EN
    chk("tog_amp", amplitude, 255);
`endif

    for (int w = 0; w < 14; w++) begin
      lo = $urandom_range(0, 100);
      hi = lo + $urandom_range(6, 150);
      st = $urandom_range(1, 3);
      nz = 1'($urandom_range(0, 1));
      for (int x = lo; x < hi; x += st) rsample(x, nz);
      for (int x = hi; x > lo; x -= st) rsample(x, nz);
    end

    wave(0);
    for (int x = 0; x < 256; x++) drive(1, 1, x);
    for (int x = 254; x >= 100; x--) drive(1, 1, x);
    drive(0, 0, 0);
    chk("mid_rst_peak", peak_val, 0);
    chk("mid_rst_trough", trough_val, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_dir", dir_up, 0);
    chk("mid_rst_locked", locked, 0);
    n_meas = 0;
    for (int x = 99; x >= 1; x--) drive(1, 1, x);
    wave(0);
    wave(0);
    for (int x = 0; x <= 2; x++) drive(1, 1, x);
    chk("post_rst_nmeas", n_meas, 2);
    chk("post_rst_period", period, 510);
    chk("post_rst_locked", locked, 1);

    n_meas = 0;
    fall_k = -1;
    for (int k = 1; k <= 70000; k++) begin
      drive(1, 1, 80);
      if (fall_k < 0 && !locked) fall_k = k;
    end
    chk("flat_fall_at", fall_k, 65535);
    chk("flat_nmeas", n_meas, 0);
    chk("flat_locked", locked, 0);

    n_meas = 0;
    for (int w = 0; w < 4; w++) wave(0);
    chk("relock_nmeas", n_meas, 3);
    chk("relock_period", period, 510);
    chk("relock_locked", locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_analyzer.md
WAVE_ANALYZER -- requirements
Module: wave_analyzer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter HYST, default 2, SHALL set the turning-point hysteresis in LSBs (range 1..127).
REQ-003 Port clk, input, 1, SHALL be the rising-edge clock.
REQ-004 Port rst_n, input, 1, SHALL be the synchronous active-low reset.
REQ-005 Port sample_valid, input, 1, SHALL qualify sample_in; the block has no backpressure.
REQ-006 Port sample_in, input, 8, SHALL carry the unsigned DAC-domain sample.
REQ-007 Port peak_val, output, 8, SHALL hold the last confirmed maximum.
REQ-008 Port trough_val, output, 8, SHALL hold the last confirmed minimum.
REQ-009 Port period, output, 16, SHALL hold the last trough-to-trough count of valid samples.
REQ-010 Port meas_valid, output, 1, SHALL pulse one cycle when trough_val and period update.
REQ-011 Port dir_up, output, 1, SHALL be 1 in RISING and 0 otherwise.
REQ-012 Port locked, output, 1, SHALL indicate two consecutive completed period measurements.

Function
REQ-013 The FSM SHALL have states IDLE, RISING and FALLING, and SHALL advance only on sample_valid.
REQ-014 In IDLE, the first valid sample SHALL load run_max = run_min = sample_in, clear the sample counter and enter RISING.
REQ-015 In RISING:
- Track run_max = max(run_max, sample_in).
- When sample_in + HYST <= run_max (9-bit compare, no underflow), latch peak_val = run_max, load run_min = sample_in and enter FALLING.
REQ-016 In FALLING:
- Track run_min = min(run_min, sample_in).
- When sample_in >= run_min + HYST (9-bit compare, no overflow), latch trough_val = run_min, load run_max = sample_in and enter RISING.
REQ-017 The sample counter SHALL increment on every valid sample and SHALL saturate at 65535.
REQ-018 On trough confirmation with a prior trough recorded, the block SHALL:
- latch period = counter value including the confirming sample;
- reset the counter to 0;
- pulse meas_valid on the next cycle.
REQ-019 The first trough confirmation after reset SHALL only restart the counter and SHALL NOT pulse meas_valid.
REQ-020 Registered outputs SHALL update on the clock edge following the confirming sample, i.e. one cycle of latency.
REQ-021 locked SHALL set on the second consecutive meas_valid.
REQ-022 locked SHALL clear when the counter saturates; saturation SHALL also discard the prior-trough record, so the next trough restarts the count without meas_valid.
REQ-023 Samples equal to the running extreme SHALL NOT trigger a turning point; a flat input SHALL hold the current state indefinitely.
REQ-024 Idle cycles with sample_valid=0 SHALL change no state and SHALL NOT count.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL set:
- FSM = IDLE;
- peak_val = 0, trough_val = 0, period = 0;
- meas_valid = 0, dir_up = 0, locked = 0;
- counter = 0, prior-trough flag cleared.
REQ-026 Reset mid-measurement SHALL discard partial extremes; the first trough after reset SHALL NOT produce meas_valid.

Configuration
REQ-027 Macro WAVE_ANALYZER_AMP_EN, when defined, SHALL add output amplitude (8 bits) = peak_val - trough_val, registered with meas_valid and reset to 0.
REQ-028 If peak_val < trough_val (transient), amplitude SHALL be 0.
REQ-029 Without WAVE_ANALYZER_AMP_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package wave_pkg SHALL hold the FSM state enum, SAMPLE_W = 8, PERIOD_W = 16 and the HYST default.
REQ-031 Sub-module wave_extreme_tracker SHALL hold the running max/min register and the hysteresis compare; it is instantiated once.

Verification
REQ-032 Clean triangle 0..255..1 repeated, valid every cycle, HYST=2 -> from the second trough: peak_val=255, trough_val=0, period=510, meas_valid every 510 samples; locked after the third trough; amplitude=255 when enabled.
REQ-033 Same triangle with sample_valid toggling 1/0 -> identical period=510; meas_valid spacing 1020 cycles.
REQ-034 Triangle 100..150..100 with ±1 LSB noise, HYST=4 -> no spurious turning points; peak_val in 149..151; trough_val in 99..101; period=100±2.
REQ-035 Constant input 80 for 70000 valid samples after lock -> locked falls when the counter reaches 65535; no meas_valid; the next triangle relocks after three troughs.
REQ-036 Assert rst_n=0 for one cycle mid-FALLING -> all outputs 0 the next cycle; the first subsequent trough gives no meas_valid; the second gives correct period.
